fifo_shift_rd_packer: RTL
=========================

// Module: fifo_shift_rd_packer
// PURPOSE
//  Read-side consumer of the show-ahead (prefetch) byte FIFO. Pops bytes via the FIFO's rd_en/rd_vld
//  handshake and packs BYTES_PER_WORD bytes into one word, little-endian. Presents each word on a
//  valid/ready stream to the downstream datapath. A flush request emits a partial word with byte-keep.
// PARAMETERS
//  BYTES_PER_WORD  4   bytes per output word; legal 2..16
//  DATA_WIDTH      8   FIFO read data width; equals the FIFO RD_DATA_WIDTH
//  CNT_WIDTH       16  width of the emitted-word counter
// PORTS
//  clk           in   1                          single clock, shared with FIFO rd side
//  rst           in   1                          synchronous, active-high reset
//  fifo_rd_en    out  1                          pop request to FIFO rd_en
//  fifo_rd_vld   in   1                          FIFO rd_vld: head data valid on fifo_rd_data this cycle
//  fifo_rd_data  in   DATA_WIDTH                 FIFO head data (show-ahead)
//  flush         in   1                          1-cycle pulse: emit partial word
//  flush_done    out  1                          1-cycle pulse: flush serviced
//  out_valid     out  1                          output word valid
//  out_ready     in   1                          downstream accept
//  out_data      out  BYTES_PER_WORD*DATA_WIDTH  packed word; lane0 = bits[DATA_WIDTH-1:0] = first byte popped
//  out_keep      out  BYTES_PER_WORD             per-lane valid; all ones for a full word
//  out_last      out  1                          word produced by flush
//  word_cnt      out  CNT_WIDTH                  count of out handshakes; wraps
// BEHAVIOUR
//  - Reset: fifo_rd_en=0, flush_done=0, out_valid=0, out_data=0, out_keep=0, out_last=0, word_cnt=0.
//    Reset clears the accumulator, byte_idx and flush_pend, and discards any held word.
//    Reset mid-word loses the partial bytes. The FIFO is reset by the same rst.
//  - Pop: pop = fifo_rd_en & fifo_rd_vld. Byte is taken in the same cycle.
//    fifo_rd_en while fifo_rd_vld=0 is harmless: no pop occurs and no state changes.
//  - Pop stores the byte in lane byte_idx, then increments byte_idx (0..BYTES_PER_WORD-1).
//  - Accumulator and output register are separate: one word is held while the next is collected.
//  - States: COLLECT, FULL_WAIT.
//    COLLECT: fifo_rd_en = ~flush_pend.
//    A pop into the last lane completes the word. If out slot is free (out_valid=0 or out_ready=1 this
//      cycle), the word moves to out next cycle and byte_idx becomes 0; state stays COLLECT.
//      Otherwise go to FULL_WAIT.
//    FULL_WAIT: fifo_rd_en=0. On out_ready=1 the word moves to out, byte_idx becomes 0, go to COLLECT.
//  - Latency: last-byte pop at cycle t gives out_valid=1 at t+1. Sustained rate is 1 byte/clk with
//    out_ready held high.
//  - Output: out_data/keep/last stay stable while out_valid=1 and out_ready=0.
//    out_valid drops after a handshake unless a new word loads in the same cycle (back-to-back).
//  - Flush:
//    flush sets flush_pend, which blocks further pops from the next cycle.
//    A pop in the flush cycle itself is kept and included in the flushed word.
//    Service condition: flush_pend=1, state COLLECT, out slot free.
//      byte_idx>0: move the partial word; out_keep = lower byte_idx bits set; upper lanes of out_data
//        are 0; out_last=1.
//      byte_idx==0: no word is emitted.
//    On service: flush_pend clears and flush_done pulses the next cycle.
//    A flush while flush_pend=1 is absorbed and produces no second flush_done.
//    If the flush cycle completes a full word: that word goes out with out_last=0.
//      The accumulator is then empty, so flush_done follows with no extra word.
//  - word_cnt increments on out_valid & out_ready and wraps at 2^CNT_WIDTH.
// STRUCTURE
//  - Package fifo_shift_pkg: state enum {COLLECT, FULL_WAIT}; LANE_W = DATA_WIDTH; BYTES_PER_WORD default.
//  - Sub-module fifo_shift_out_slot: valid/ready holding register for data/keep/last, with load and
//    accept handshake. The packer instantiates it once.
// TESTING
//  1 Reset, FIFO preloaded 0x01..0x08, out_ready=1 -> words 0x04030201, 0x08070605, keep=4'hF,
//    last=0, word_cnt=2, no gaps (1 byte/clk).
//  2 out_ready=0 while 12 bytes available -> exactly 8 bytes popped, fifo_rd_en=0 in FULL_WAIT,
//    out_data stable. Release out_ready -> remaining word follows.
//  3 3 bytes 0xAA,0xBB,0xCC then flush -> out_data=0x00CCBBAA, keep=4'b0111, last=1, flush_done
//    1 cycle after service.
//  4 flush coincident with the 4th-byte pop -> full word, keep=4'hF, last=0. Then flush_done with
//    no extra word. flush on empty accumulator -> flush_done only.
//  5 fifo_rd_vld toggled randomly, out_ready random -> output byte stream equals input byte stream.
//    No pop while fifo_rd_vld=0.
//  6 rst asserted after 2 bytes of a word and while out_valid=1 -> all outputs 0 next cycle, word_cnt=0.
//    The next 4 bytes form a fresh word.

Source files
------------

// File: rtl/fifo_shift_pkg.sv
// Shared types and defaults for the show-ahead FIFO read-side packer.
package fifo_shift_pkg;

  localparam int unsigned LANE_W             = 8;
  localparam int unsigned BYTES_PER_WORD_DEF = 4;

  typedef enum logic [0:0] {
    COLLECT   = 1'b0,
    FULL_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_shift_out_slot.sv
// Single-entry valid/ready holding register for one packed word.
module fifo_shift_out_slot #(
  parameter int unsigned DW = 32,
  parameter int unsigned KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [KW-1:0] load_keep,
  input  logic          load_last,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [KW-1:0] out_keep,
  output logic          out_last,
  output logic          free,
  output logic          accept
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q,  data_d;
  logic [KW-1:0] keep_q,  keep_d;
  logic          last_q,  last_d;

  assign free      = ~valid_q | out_ready;
  assign accept    = valid_q & out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      keep_d  = load_keep;
      last_d  = load_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/fifo_shift_rd_packer.sv
// Pops bytes from a show-ahead FIFO and packs them little-endian into words.
module fifo_shift_rd_packer
  import fifo_shift_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int unsigned DATA_WIDTH     = LANE_W,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic                                 fifo_rd_en,
  input  logic                                 fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0]                fifo_rd_data,
  input  logic                                 flush,
  output logic                                 flush_done,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BYTES_PER_WORD*DATA_WIDTH-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]            out_keep,
  output logic                                 out_last,
  output logic [CNT_WIDTH-1:0]                 word_cnt
);

  localparam int unsigned WW = BYTES_PER_WORD * DATA_WIDTH;
  localparam int unsigned IW = $clog2(BYTES_PER_WORD);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_WORD - 1);

  state_e                state_q, state_d;
  logic [WW-1:0]         acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  flush_done_q, flush_done_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;

  logic                  rd_en, pop;
  logic [WW-1:0]         word_with_byte;
  logic                  slot_free, slot_accept, slot_load;
  logic [WW-1:0]         load_data;
  logic [BYTES_PER_WORD-1:0] load_keep;
  logic                  load_last;

  assign fifo_rd_en = rd_en;
  assign flush_done = flush_done_q;
  assign word_cnt   = word_cnt_q;

  // Pop/pack/flush control; the completed word is handed to the slot or parked in FULL_WAIT.
  always_comb begin
    rd_en          = ~rst & (state_q == COLLECT) & ~flush_pend_q;
    pop            = rd_en & fifo_rd_vld;
    state_d        = state_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    flush_pend_d   = flush_pend_q;
    flush_done_d   = 1'b0;
    word_cnt_d     = word_cnt_q;
    slot_load      = 1'b0;
    load_data      = acc_q;
    load_keep      = '1;
    load_last      = 1'b0;
    word_with_byte = acc_q;

    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      if (idx_q == IW'(i)) begin
        word_with_byte[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
      end
    end

    if (slot_accept) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end

    // A flush arriving while one is pending is absorbed; the service branch below clears it.
    if (flush) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      COLLECT: begin
        if (pop) begin
          if (idx_q == LAST_IDX) begin
            if (slot_free) begin
              slot_load = 1'b1;
              load_data = word_with_byte;
              acc_d     = '0;
              idx_d     = '0;
            end else begin
              acc_d   = word_with_byte;
              state_d = FULL_WAIT;
            end
          end else begin
            acc_d = word_with_byte;
            idx_d = idx_q + 1'b1;
          end
        end else if (flush_pend_q && slot_free) begin
          flush_pend_d = 1'b0;
          flush_done_d = 1'b1;
          if (idx_q != '0) begin
            slot_load = 1'b1;
            load_data = acc_q;
            load_last = 1'b1;
            for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
              load_keep[i] = (i < 32'(idx_q));
            end
            acc_d = '0;
            idx_d = '0;
          end
        end
      end
      FULL_WAIT: begin
        if (out_ready) begin
          slot_load = 1'b1;
          load_data = acc_q;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      acc_q        <= '0;
      idx_q        <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  fifo_shift_out_slot #(
    .DW (WW),
    .KW (BYTES_PER_WORD)
  ) u_out_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .load_data (load_data),
    .load_keep (load_keep),
    .load_last (load_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .free      (slot_free),
    .accept    (slot_accept)
  );

endmodule
